key_sw_dev: RTL and testbench
=============================

KEY_SW_DEV -- requirements
Module: key_sw_dev

Interface
REQ-001 Parameter DBITS, default 16, data/address bus width.
REQ-002 Parameter DEB_CYCLES, default 500000, consecutive stable cycles required to accept an input change.
REQ-003 Parameter DEB_BITS, default 20, debounce counter width; SHALL satisfy 2^DEB_BITS > DEB_CYCLES.
REQ-004 Clocking and reset: one clock; reset is synchronous and active-high.
REQ-005 Port clk, input, 1, sole clock; all state updates on posedge clk.
REQ-006 Port reset, input, 1, synchronous active-high reset.
REQ-007 Port addr, input, DBITS, data-bus address from processor.
REQ-008 Port wdata, input, DBITS, store data.
REQ-009 Port we, input, 1, store strobe, valid one cycle.
REQ-010 Port re, input, 1, load strobe; qualifies read side effects only.
REQ-011 Port rdata, output, DBITS, combinational load data for addr.
REQ-012 Port sel, output, 1, high when addr is in 16'hFFF0..16'hFFF6 (even addresses).
REQ-013 Port irq, output, 1, registered interrupt request.
REQ-014 Port key, input, 4, raw board keys, asynchronous, active-low.
REQ-015 Port sw, input, 10, raw board switches, asynchronous.

Function
REQ-016 Register map: FFF0 KDATA (RO, {12'b0,kdeb}); FFF2 SDATA (RO, {6'b0,sdeb}); FFF4 KCTRL; FFF6 SCTRL.
REQ-017 CTRL layout: bit0 READY, bit2 OVERRUN, bit8 IE; all other bits read 0.
REQ-018 Unmapped addr SHALL give rdata 16'hDEAD and sel 0.
REQ-019 key and sw each pass through a 2-flop synchronizer before use.
REQ-020 Per group (keys, switches), one counter: synchronized value equals debounced value -> counter cleared to 0; otherwise counter increments.
REQ-021 When counter reaches DEB_CYCLES-1 while still differing, debounced value loads the synchronized vector and the counter clears; total latency from a stable raw change is 2 + DEB_CYCLES cycles.
REQ-022 Any bounce back to the debounced value before acceptance SHALL restart the count.
REQ-023 On debounced update: READY set to 1; if READY was already 1, OVERRUN set to 1.
REQ-024 re with addr FFF0 (FFF2) SHALL clear KCTRL (SCTRL) READY on the next edge.
REQ-025 Read-clear and debounced update in the same cycle: set wins; READY stays 1, and OVERRUN is not set by that event.
REQ-026 we to CTRL: bit8 loads IE; writing 0 to bit0/bit2 clears READY/OVERRUN; writing 1 has no effect; set from a same-cycle update wins.
REQ-027 we to KDATA/SDATA or unmapped addresses SHALL be ignored.
REQ-028 irq next-cycle = (KREADY & KIE) | (SREADY & SIE).
REQ-029 rdata SHALL be independent of re and we.

Reset
REQ-030 reset: synchronizer flops and kdeb = 4'hF, sw synchronizers and sdeb = 10'h000, counters 0, READY/OVERRUN/IE 0, irq 0.
REQ-031 Mid-debounce reset SHALL discard the pending change; counting restarts after reset deasserts.
REQ-032 Switches held high through reset SHALL be accepted as a normal change after 2 + DEB_CYCLES cycles.

Configuration
REQ-033 Macro KEYSW_IRQ_EN: defined -> IE bits and irq behave per REQ-026/028.
REQ-034 KEYSW_IRQ_EN undefined -> IE bits read 0 and ignore writes, irq constant 0, no IE or irq flops; all other behaviour unchanged.

Verification (DEB_CYCLES=4)
REQ-035 Reset, key=4'hF, read FFF0 -> rdata 16'h000F; read FFF4 -> 16'h0000; irq 0.
REQ-036 key 4'hF->4'hE held -> kdeb = 4'hE and KREADY 1 exactly 6 cycles after change; read FFF0 returns 16'h000E; next read FFF4 returns 16'h0000.
REQ-037 key toggles E/F every 2 cycles for 20 cycles, then holds F -> KDATA stays 16'h000F and KREADY stays 0.
REQ-038 sw 0->3FF accepted, unread, then 3FF->001 accepted -> SCTRL = 16'h0005; write 16'h0000 to FFF6 -> 16'h0000.
REQ-039 With KEYSW_IRQ_EN: write 16'h0100 to FFF4, key change accepted -> irq 1 one cycle after READY; read FFF0 -> irq 0 two cycles later.
REQ-040 Read-clear of FFF2 on the same cycle as an sdeb update -> SREADY remains 1, OVERRUN 0.

Source files
------------

// File: rtl/key_sw_dev.sv
// Memory-mapped key/switch device: synchronizes and debounces 4 keys and 10 switches,
// exposes data/control registers at FFF0..FFF6; interrupt logic is built only with KEYSW_IRQ_EN.
module key_sw_dev #(
    parameter int DBITS      = 16,
    parameter int DEB_CYCLES = 500000,
    parameter int DEB_BITS   = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DBITS-1:0] addr,
    input  logic [DBITS-1:0] wdata,
    input  logic             we,
    input  logic             re,
    output logic [DBITS-1:0] rdata,
    output logic             sel,
    output logic             irq,
    input  logic [3:0]       key,
    input  logic [9:0]       sw
);

    localparam logic [DBITS-1:0]    A_KDATA  = DBITS'(16'hFFF0);
    localparam logic [DBITS-1:0]    A_SDATA  = DBITS'(16'hFFF2);
    localparam logic [DBITS-1:0]    A_KCTRL  = DBITS'(16'hFFF4);
    localparam logic [DBITS-1:0]    A_SCTRL  = DBITS'(16'hFFF6);
    localparam logic [DBITS-1:0]    UNMAPPED = DBITS'(16'hDEAD);
    localparam logic [DEB_BITS-1:0] CNT_LAST = DEB_BITS'(DEB_CYCLES - 1);

    logic [3:0]          r_key_s1, r_key_s2, r_kdeb;
    logic [9:0]          r_sw_s1, r_sw_s2, r_sdeb;
    logic [DEB_BITS-1:0] r_kcnt, r_scnt;
    logic                r_kready, r_kovr, r_sready, r_sovr;

    logic w_kdiff, w_sdiff, w_kupd, w_supd;
    logic w_a_kdata, w_a_sdata, w_a_kctrl, w_a_sctrl;
    logic w_k_wr, w_s_wr;
    logic w_k_rdy_clr, w_s_rdy_clr, w_k_ovr_clr, w_s_ovr_clr;
    logic w_k_ovr_set, w_s_ovr_set;
    logic w_kie, w_sie;
    logic [DBITS-1:0] w_kctrl, w_sctrl;
    logic w_unused;

    // An update fires on the cycle the counter has seen DEB_CYCLES consecutive differing samples.
    assign w_kdiff = (r_key_s2 != r_kdeb);
    assign w_sdiff = (r_sw_s2 != r_sdeb);
    assign w_kupd  = w_kdiff && (r_kcnt == CNT_LAST);
    assign w_supd  = w_sdiff && (r_scnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_key_s1 <= 4'hF;
            r_key_s2 <= 4'hF;
            r_kdeb   <= 4'hF;
            r_kcnt   <= '0;
        end else begin
            r_key_s1 <= key;
            r_key_s2 <= r_key_s1;
            if (!w_kdiff) begin
                r_kcnt <= '0;
            end else if (w_kupd) begin
                r_kdeb <= r_key_s2;
                r_kcnt <= '0;
            end else begin
                r_kcnt <= r_kcnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sw_s1 <= 10'h000;
            r_sw_s2 <= 10'h000;
            r_sdeb  <= 10'h000;
            r_scnt  <= '0;
        end else begin
            r_sw_s1 <= sw;
            r_sw_s2 <= r_sw_s1;
            if (!w_sdiff) begin
                r_scnt <= '0;
            end else if (w_supd) begin
                r_sdeb <= r_sw_s2;
                r_scnt <= '0;
            end else begin
                r_scnt <= r_scnt + 1'b1;
            end
        end
    end

    assign w_a_kdata = (addr == A_KDATA);
    assign w_a_sdata = (addr == A_SDATA);
    assign w_a_kctrl = (addr == A_KCTRL);
    assign w_a_sctrl = (addr == A_SCTRL);
    assign w_k_wr    = we & w_a_kctrl;
    assign w_s_wr    = we & w_a_sctrl;

    // A READY being cleared this cycle does not count as "already ready" for overrun purposes.
    assign w_k_rdy_clr = (re & w_a_kdata) | (w_k_wr & ~wdata[0]);
    assign w_s_rdy_clr = (re & w_a_sdata) | (w_s_wr & ~wdata[0]);
    assign w_k_ovr_clr = w_k_wr & ~wdata[2];
    assign w_s_ovr_clr = w_s_wr & ~wdata[2];
    assign w_k_ovr_set = w_kupd & r_kready & ~w_k_rdy_clr;
    assign w_s_ovr_set = w_supd & r_sready & ~w_s_rdy_clr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_kready <= 1'b0;
            r_kovr   <= 1'b0;
            r_sready <= 1'b0;
            r_sovr   <= 1'b0;
        end else begin
            if (w_kupd)           r_kready <= 1'b1;
            else if (w_k_rdy_clr) r_kready <= 1'b0;
            if (w_k_ovr_set)      r_kovr   <= 1'b1;
            else if (w_k_ovr_clr) r_kovr   <= 1'b0;
            if (w_supd)           r_sready <= 1'b1;
            else if (w_s_rdy_clr) r_sready <= 1'b0;
            if (w_s_ovr_set)      r_sovr   <= 1'b1;
            else if (w_s_ovr_clr) r_sovr   <= 1'b0;
        end
    end

`ifdef KEYSW_IRQ_EN
    logic r_kie, r_sie, r_irq;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_kie <= 1'b0;
            r_sie <= 1'b0;
            r_irq <= 1'b0;
        end else begin
            if (w_k_wr) r_kie <= wdata[8];
            if (w_s_wr) r_sie <= wdata[8];
            r_irq <= (r_kready & r_kie) | (r_sready & r_sie);
        end
    end

    assign w_kie = r_kie;
    assign w_sie = r_sie;
    assign irq   = r_irq;
`else
    assign w_kie = 1'b0;
    assign w_sie = 1'b0;
    assign irq   = 1'b0;
`endif

    assign w_kctrl  = DBITS'({w_kie, 5'b0, r_kovr, 1'b0, r_kready});
    assign w_sctrl  = DBITS'({w_sie, 5'b0, r_sovr, 1'b0, r_sready});
    assign w_unused = ^wdata;

    // Read data depends on addr only; odd addresses inside the window are unmapped.
    always_comb begin
        rdata = UNMAPPED;
        sel   = 1'b0;
        if (w_a_kdata) begin
            rdata = DBITS'(r_kdeb);
            sel   = 1'b1;
        end else if (w_a_sdata) begin
            rdata = DBITS'(r_sdeb);
            sel   = 1'b1;
        end else if (w_a_kctrl) begin
            rdata = w_kctrl;
            sel   = 1'b1;
        end else if (w_a_sctrl) begin
            rdata = w_sctrl;
            sel   = 1'b1;
        end
    end

endmodule

// File: tb/tb_key_sw_dev.sv
// Bench for key_sw_dev with DEB_CYCLES=4: register decode table plus debounce, status and interrupt sequences.
module tb_key_sw_dev;

    localparam int DBITS      = 16;
    localparam int DEB_CYCLES = 4;
    localparam int DEB_BITS   = 3;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] addr  = 16'h0000;
    logic [15:0] wdata = 16'h0000;
    logic        we    = 1'b0;
    logic        re    = 1'b0;
    logic [3:0]  key   = 4'hF;
    logic [9:0]  sw    = 10'h000;
    logic [15:0] rdata;
    logic        sel;
    logic        irq;

    always #5 clk = ~clk;

    key_sw_dev #(
        .DBITS(DBITS),
        .DEB_CYCLES(DEB_CYCLES),
        .DEB_BITS(DEB_BITS)
    ) u_dut (
        .clk(clk),
        .reset(reset),
        .addr(addr),
        .wdata(wdata),
        .we(we),
        .re(re),
        .rdata(rdata),
        .sel(sel),
        .irq(irq),
        .key(key),
        .sw(sw)
    );

    logic [15:0] exp_q[$];
    string       name_q[$];
    int          n_vec = 0;
    int          n_err = 0;

    typedef struct {
        logic [15:0] addr;
        logic        we;
        logic        re;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
        logic        exp_sel;
    } vec_t;

    vec_t tbl[13];

    task automatic expect_val(input string nm, input logic [15:0] e);
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic compare(input logic [15:0] act);
        logic [15:0] e;
        string       nm;
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        n_vec++;
        if (act !== e) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, e);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rd_check(input string nm, input logic [15:0] a, input logic [15:0] e);
        addr = a;
        expect_val(nm, e);
        #1;
        compare(rdata);
    endtask

    task automatic irq_check(input string nm, input logic e);
        expect_val(nm, {15'b0, e});
        compare({15'b0, irq});
    endtask

    task automatic rd_clear(input logic [15:0] a);
        addr = a;
        re   = 1'b1;
        @(negedge clk);
        re   = 1'b0;
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        @(negedge clk);
        we    = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{16'hFFF0, 1'b0, 1'b0, 16'h0000, 16'h000F, 1'b1};
        tbl[1]  = '{16'hFFF2, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1};
        tbl[2]  = '{16'hFFF4, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1};
        tbl[3]  = '{16'hFFF6, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1};
        tbl[4]  = '{16'hFFF1, 1'b0, 1'b0, 16'h0000, 16'hDEAD, 1'b0};
        tbl[5]  = '{16'hFFF8, 1'b0, 1'b0, 16'h0000, 16'hDEAD, 1'b0};
        tbl[6]  = '{16'hFFEE, 1'b0, 1'b0, 16'h0000, 16'hDEAD, 1'b0};
        tbl[7]  = '{16'h0000, 1'b0, 1'b0, 16'h0000, 16'hDEAD, 1'b0};
        tbl[8]  = '{16'hFFF0, 1'b1, 1'b0, 16'h1234, 16'h000F, 1'b1};
        tbl[9]  = '{16'hFFF3, 1'b1, 1'b0, 16'hFFFF, 16'hDEAD, 1'b0};
        tbl[10] = '{16'hFFF2, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b1};
        tbl[11] = '{16'hFFF0, 1'b0, 1'b0, 16'h0000, 16'h000F, 1'b1};
        tbl[12] = '{16'hFFF7, 1'b0, 1'b0, 16'h0000, 16'hDEAD, 1'b0};

        // Reset and register decode
        tick(3);
        reset = 1'b0;
        irq_check("irq_after_reset", 1'b0);
        for (int i = 0; i < 13; i++) begin
            addr  = tbl[i].addr;
            we    = tbl[i].we;
            re    = tbl[i].re;
            wdata = tbl[i].wdata;
            expect_val($sformatf("tbl%0d_rdata", i), tbl[i].exp_rdata);
            expect_val($sformatf("tbl%0d_sel", i), {15'b0, tbl[i].exp_sel});
            #1;
            compare(rdata);
            compare({15'b0, sel});
            tick(1);
        end
        we = 1'b0;
        re = 1'b0;

        // Key acceptance latency is exactly 6 cycles
        key = 4'hE;
        tick(5);
        rd_check("kdata_before_accept", 16'hFFF0, 16'h000F);
        rd_check("kctrl_before_accept", 16'hFFF4, 16'h0000);
        tick(1);
        rd_check("kdata_accept", 16'hFFF0, 16'h000E);
        rd_check("kctrl_accept", 16'hFFF4, 16'h0001);
        rd_clear(16'hFFF0);
        rd_check("kctrl_after_readclr", 16'hFFF4, 16'h0000);
        rd_check("kdata_after_readclr", 16'hFFF0, 16'h000E);
        key = 4'hF;
        tick(6);
        rd_check("kdata_restore", 16'hFFF0, 16'h000F);
        rd_check("kctrl_restore", 16'hFFF4, 16'h0001);
        rd_clear(16'hFFF0);
        rd_check("kctrl_restore_clr", 16'hFFF4, 16'h0000);

        // Bouncing keys never settle long enough
        for (int i = 0; i < 10; i++) begin
            key = (i % 2 == 0) ? 4'hE : 4'hF;
            tick(2);
        end
        key = 4'hF;
        tick(8);
        rd_check("kdata_bounce", 16'hFFF0, 16'h000F);
        rd_check("kctrl_bounce", 16'hFFF4, 16'h0000);

        // Raw pulse one cycle too short is rejected
        key = 4'hE;
        tick(3);
        key = 4'hF;
        tick(8);
        rd_check("kdata_short_pulse", 16'hFFF0, 16'h000F);
        rd_check("kctrl_short_pulse", 16'hFFF4, 16'h0000);

        // Minimum-length pulse is accepted, the return then overruns
        key = 4'hE;
        tick(4);
        key = 4'hF;
        tick(2);
        rd_check("kdata_min_pulse", 16'hFFF0, 16'h000E);
        rd_check("kctrl_min_pulse", 16'hFFF4, 16'h0001);
        tick(6);
        rd_check("kdata_return", 16'hFFF0, 16'h000F);
        rd_check("kctrl_overrun", 16'hFFF4, 16'h0005);
        wr(16'hFFF4, 16'h0005);
        rd_check("kctrl_write_ones", 16'hFFF4, 16'h0005);
        wr(16'hFFF4, 16'h0001);
        rd_check("kctrl_clear_ovr", 16'hFFF4, 16'h0001);
        wr(16'hFFF4, 16'h0000);
        rd_check("kctrl_clear_all", 16'hFFF4, 16'h0000);

        // Switch double update without read gives overrun
        sw = 10'h3FF;
        tick(6);
        rd_check("sdata_3ff", 16'hFFF2, 16'h03FF);
        rd_check("sctrl_first", 16'hFFF6, 16'h0001);
        sw = 10'h001;
        tick(6);
        rd_check("sdata_001", 16'hFFF2, 16'h0001);
        rd_check("sctrl_overrun", 16'hFFF6, 16'h0005);
        wr(16'hFFF6, 16'h0000);
        rd_check("sctrl_wclear", 16'hFFF6, 16'h0000);
        rd_check("kctrl_untouched", 16'hFFF4, 16'h0000);

        // Read-clear coinciding with an update: set wins, no overrun
        sw = 10'h002;
        tick(6);
        rd_check("sctrl_pre_collide", 16'hFFF6, 16'h0001);
        sw = 10'h006;
        tick(5);
        rd_check("sdata_pre_collide", 16'hFFF2, 16'h0002);
        rd_clear(16'hFFF2);
        rd_check("sdata_collide", 16'hFFF2, 16'h0006);
        rd_check("sctrl_collide", 16'hFFF6, 16'h0001);

        // Reset mid-debounce discards; held switches accepted afterwards
        sw = 10'h3FF;
        tick(3);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        rd_check("sdata_post_reset", 16'hFFF2, 16'h0000);
        rd_check("sctrl_post_reset", 16'hFFF6, 16'h0000);
        rd_check("kdata_post_reset", 16'hFFF0, 16'h000F);
        irq_check("irq_post_reset", 1'b0);
        tick(5);
        rd_check("sdata_held_pending", 16'hFFF2, 16'h0000);
        tick(1);
        rd_check("sdata_held_accept", 16'hFFF2, 16'h03FF);
        rd_check("sctrl_held_accept", 16'hFFF6, 16'h0001);

        // Interrupt enable and request
`ifdef KEYSW_IRQ_EN
        wr(16'hFFF4, 16'h0100);
        rd_check("kctrl_ie", 16'hFFF4, 16'h0100);
        key = 4'hE;
        tick(6);
        rd_check("kctrl_ie_ready", 16'hFFF4, 16'h0101);
        irq_check("irq_same_cycle_as_ready", 1'b0);
        tick(1);
        irq_check("irq_asserted", 1'b1);
        rd_clear(16'hFFF0);
        irq_check("irq_one_after_read", 1'b1);
        rd_check("kctrl_ie_cleared", 16'hFFF4, 16'h0100);
        tick(1);
        irq_check("irq_deasserted", 1'b0);
`else
        wr(16'hFFF4, 16'h0100);
        rd_check("kctrl_ie_ignored", 16'hFFF4, 16'h0000);
        key = 4'hE;
        tick(7);
        rd_check("kctrl_noie_ready", 16'hFFF4, 16'h0001);
        irq_check("irq_disabled", 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
